// File: rtl/cut_eval_sched.sv
// Shared cut-function evaluator: round-robin arbiter feeding one registered f(a,b,c,d) = b & ~(a^c^d) slot.
// Latency: 1 cycle from grant (req_ready high) to rsp_valid; 1 result/cycle sustained with rsp_ready high.
// Backpressure: while the result slot is full and rsp_ready is low, no grant is issued and outputs hold.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid[NREQ]      per-requester request valid
//   req_vec[4*NREQ]      requester i nibble at [4i +: 4] = {d,c,b,a}
//   req_ready[NREQ]      one-hot grant, combinational from req_valid, slot state and rsp_ready
//   rsp_valid/id/data    registered result slot, handshake with rsp_ready
//   clr_cnt              synchronous clear of both activity counters (wins over increment)
//   eval_cnt, toggle_cnt saturating counts of loads and of loads that changed rsp_data
module cut_eval_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_vec,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_data,
  input  logic                rsp_ready,
  input  logic                clr_cnt,
  output logic [CNT_W-1:0]    eval_cnt,
  output logic [CNT_W-1:0]    toggle_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // One requester's input nibble, LSB is 'a'.
  typedef struct packed {
    logic d;
    logic c;
    logic b;
    logic a;
  } cut_in_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] winner;
  logic           found;
  logic           load_ok;
  logic           load;
  cut_in_t        sel_vec;
  logic           f_new;

  // Rotating-priority scan: candidates last+1, last+2, ... wrapping at NREQ.
  // The first valid one wins; later hits are ignored by the found flag.
  always_comb begin : arb_scan
    logic [IDW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The slot can take a new result when empty, or when the current one
  // is being consumed this same cycle (no bubble under full throughput).
  assign load_ok = (state == EMPTY) || (rsp_ready && (state == FULL));
  assign load    = found && load_ok;

  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign sel_vec = cut_in_t'(req_vec[{winner, 2'b00} +: 4]);
  assign f_new   = sel_vec.b & ~(sel_vec.a ^ sel_vec.c ^ sel_vec.d);

  // Result slot FSM; rsp_id/rsp_data only change on a load, so a drain
  // leaves the last result visible (but not valid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rsp_id   <= '0;
      rsp_data <= 1'b0;
      last     <= IDW'(NREQ - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state    <= FULL;
            rsp_id   <= winner;
            rsp_data <= f_new;
            last     <= winner;
          end
        end
        FULL: begin
          if (load) begin
            rsp_id   <= winner;
            rsp_data <= f_new;
            last     <= winner;
          end else if (rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state == FULL);

  // Activity counters. The previously loaded result is exactly rsp_data:
  // both reset to 0 and both are rewritten on every load (including a
  // load that coincides with clr_cnt), so no separate copy is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (clr_cnt) begin
      eval_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (load) begin
      if (eval_cnt != '1) begin
        eval_cnt <= eval_cnt + 1'b1;
      end
      if ((f_new != rsp_data) && (toggle_cnt != '1)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cut_eval_sched.sv
// Self-checking bench for cut_eval_sched: two instances (CNT_W=16 and CNT_W=3)
// share one stimulus stream; directed table, exhaustive function sweep,
// saturation/clear, mid-transaction reset and random traffic against a model.
module tb_cut_eval_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_vec;
  logic        rsp_ready;
  logic        clr_cnt;

  logic [3:0]  rr16, rr3;
  logic        vl16, vl3;
  logic [1:0]  id16, id3;
  logic        d16, d3;
  logic [15:0] ev16, tg16;
  logic [2:0]  ev3, tg3;

  int n_chk  = 0;
  int n_fail = 0;

  cut_eval_sched #(.NREQ(4), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vec(req_vec),
    .req_ready(rr16), .rsp_valid(vl16), .rsp_id(id16), .rsp_data(d16),
    .rsp_ready(rsp_ready), .clr_cnt(clr_cnt), .eval_cnt(ev16), .toggle_cnt(tg16)
  );

  cut_eval_sched #(.NREQ(4), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vec(req_vec),
    .req_ready(rr3), .rsp_valid(vl3), .rsp_id(id3), .rsp_data(d3),
    .rsp_ready(rsp_ready), .clr_cnt(clr_cnt), .eval_cnt(ev3), .toggle_cnt(tg3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int full;
    int id;
    int data;
    int last;
    int ev;
    int tg;
    int prev;
  } mdl_t;

  localparam mdl_t MDL_RST = '{0, 0, 0, 3, 0, 0, 0};

  mdl_t m16, m3;

  // Cut function in its original sum form.
  function automatic int fref(logic [3:0] nib);
    logic a, b, c, d;
    {d, c, b, a} = nib;
    return int'((b & (c ^ d)) ^ (~a & b));
  endfunction

  function automatic int winner(mdl_t m, logic [3:0] v);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (m.last + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [3:0] v, logic [15:0] x, logic r, logic c, int maxc);
    mdl_t n;
    int w, f;
    logic [3:0] nib;
    n = m;
    w = winner(m, v);
    if (w >= 0 && (m.full == 0 || r)) begin
      nib    = x[4*w +: 4];
      f      = fref(nib);
      n.full = 1;
      n.id   = w;
      n.data = f;
      n.last = w;
      if (!c) begin
        if (n.ev < maxc) n.ev = n.ev + 1;
        if (f != m.prev && n.tg < maxc) n.tg = n.tg + 1;
      end
      n.prev = f;
    end else if (m.full == 1 && r) begin
      n.full = 0;
    end
    if (c) begin
      n.ev = 0;
      n.tg = 0;
    end
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("valid16", int'(vl16), m16.full);
    chk("id16",    int'(id16), m16.id);
    chk("data16",  int'(d16),  m16.data);
    chk("eval16",  int'(ev16), m16.ev);
    chk("tog16",   int'(tg16), m16.tg);
    chk("valid3",  int'(vl3),  m3.full);
    chk("id3",     int'(id3),  m3.id);
    chk("data3",   int'(d3),   m3.data);
    chk("eval3",   int'(ev3),  m3.ev);
    chk("tog3",    int'(tg3),  m3.tg);
  endtask

  // Called 1 time unit after a rising edge. Drives one cycle of inputs,
  // checks the combinational grant at the falling edge, then the
  // registered outputs just after the next rising edge.
  task automatic apply(input logic [3:0] v, input logic [15:0] x, input logic r,
                       input logic c, output logic [3:0] rr_seen);
    int w;
    logic [3:0] exp_rr;
    req_valid = v;
    req_vec   = x;
    rsp_ready = r;
    clr_cnt   = c;
    w = winner(m16, v);
    exp_rr = (w >= 0 && (m16.full == 0 || r)) ? 4'(1 << w) : 4'b0000;
    @(negedge clk);
    rr_seen = rr16;
    chk("req_ready16", int'(rr16), int'(exp_rr));
    chk("req_ready3",  int'(rr3),  int'(exp_rr));
    @(posedge clk);
    m16 = step(m16, v, x, r, c, 65535);
    m3  = step(m3,  v, x, r, c, 7);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_vec   = '0;
    rsp_ready = 1'b0;
    clr_cnt   = 1'b0;
    m16 = MDL_RST;
    m3  = MDL_RST;
    #1;
    check_outs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  vld;
    logic [15:0] vec;
    logic        rdy;
    logic [3:0]  rr;
    logic        vl;
    int          id;
    logic        dat;
    int          ev;
  } vec_t;

  vec_t tbl[17];
  logic [3:0] rr_seen;

  initial begin
    // Nibbles {d,c,b,a}: req0=0010 (f=1), req1=0000 (f=0), req2=0111 (f=1), req3=1111 (f=0).
    tbl[0]  = '{4'b0001, 16'h0002, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 1};
    tbl[1]  = '{4'b0000, 16'h0002, 1'b1, 4'b0000, 1'b0, 0, 1'b1, 1};
    tbl[2]  = '{4'b1111, 16'hF702, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 2};
    tbl[3]  = '{4'b1111, 16'hF702, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 3};
    tbl[4]  = '{4'b1111, 16'hF702, 1'b1, 4'b1000, 1'b1, 3, 1'b0, 4};
    tbl[5]  = '{4'b1111, 16'hF702, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 5};
    tbl[6]  = '{4'b1111, 16'hF702, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 6};
    tbl[7]  = '{4'b1111, 16'hF702, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 7};
    tbl[8]  = '{4'b1111, 16'hF702, 1'b1, 4'b1000, 1'b1, 3, 1'b0, 8};
    tbl[9]  = '{4'b1111, 16'hF702, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 9};
    tbl[10] = '{4'b1111, 16'hF702, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 9};
    tbl[11] = '{4'b1111, 16'hF702, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 9};
    tbl[12] = '{4'b1111, 16'hF702, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 9};
    tbl[13] = '{4'b1111, 16'hF702, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 9};
    tbl[14] = '{4'b1111, 16'hF702, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 9};
    tbl[15] = '{4'b1111, 16'hF702, 1'b1, 4'b0010, 1'b1, 1, 1'b0, 10};
    tbl[16] = '{4'b0000, 16'hF702, 1'b1, 4'b0000, 1'b0, 1, 1'b0, 10};

    do_reset();

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].vld, tbl[i].vec, tbl[i].rdy, 1'b0, rr_seen);
      chk("tbl_rr",    int'(rr_seen), int'(tbl[i].rr));
      chk("tbl_valid", int'(vl16),    int'(tbl[i].vl));
      chk("tbl_id",    int'(id16),    tbl[i].id);
      chk("tbl_data",  int'(d16),     int'(tbl[i].dat));
      chk("tbl_eval",  int'(ev16),    tbl[i].ev);
    end

    // Exhaustive function sweep through requester 2.
    do_reset();
    for (int v = 0; v < 16; v++) begin
      logic [3:0] nv;
      logic       e;
      nv = 4'(v);
      e  = nv[1] & ~(nv[0] ^ nv[2] ^ nv[3]);
      apply(4'b0100, {4'h0, nv, 8'h00}, 1'b1, 1'b0, rr_seen);
      chk("fn_rr",   int'(rr_seen), 4);
      chk("fn_id",   int'(id16),    2);
      chk("fn_data", int'(d16),     int'(e));
    end
    chk("fn_eval", int'(ev16), 16);

    // Saturation with alternating 1,0 results, then clear during a load.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(4'b0001, (k % 2 == 0) ? 16'h0002 : 16'h0000, 1'b1, 1'b0, rr_seen);
    end
    chk("sat_eval3",  int'(ev3),  7);
    chk("sat_tog3",   int'(tg3),  7);
    chk("sat_eval16", int'(ev16), 10);
    chk("sat_tog16",  int'(tg16), 10);
    apply(4'b0001, 16'h0002, 1'b1, 1'b1, rr_seen);
    chk("clr_eval3",  int'(ev3),  0);
    chk("clr_tog3",   int'(tg3),  0);
    chk("clr_eval16", int'(ev16), 0);
    chk("clr_tog16",  int'(tg16), 0);
    chk("clr_data",   int'(d16),  1);
    // Previous result (1, from the uncounted load) is kept, so a 0 toggles.
    apply(4'b0001, 16'h0000, 1'b1, 1'b0, rr_seen);
    chk("post_clr_eval", int'(ev16), 1);
    chk("post_clr_tog",  int'(tg16), 1);

    // Reset while FULL and stalled.
    apply(4'b0001, 16'h0002, 1'b1, 1'b0, rr_seen);
    apply(4'b1111, 16'hF702, 1'b0, 1'b0, rr_seen);
    chk("stall_valid", int'(vl16), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid16", int'(vl16), 0);
    chk("mid_rst_valid3",  int'(vl3),  0);
    chk("mid_rst_eval16",  int'(ev16), 0);
    do_reset();
    apply(4'b1111, 16'hF702, 1'b1, 1'b0, rr_seen);
    chk("post_rst_rr", int'(rr_seen), 1);
    chk("post_rst_id", int'(id16),    0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      apply(4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), rr_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
